// File: rtl/alu_seq_if.sv
// Valid/ready operand and result bundle for the sequential ALU.
interface alu_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry_in;
   logic             bnegate;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;
   logic             zero;

   modport master (
      output in_valid, a, b, carry_in, bnegate, op, out_ready,
      input  in_ready, out_valid, result, carry_out, overflow, zero
   );

   modport slave (
      input  in_valid, a, b, carry_in, bnegate, op, out_ready,
      output in_ready, out_valid, result, carry_out, overflow, zero
   );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/add/slt, iterative shifts and
// shift-add unsigned multiply, one op in flight behind valid/ready.
module alu_seq #(
   parameter int WIDTH = 16
) (
   input logic   clk,
   input logic   rst,
   alu_seq_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW:0] CNT_ONE = 1;
   localparam logic [SHW:0] CNT_MAX = WIDTH[SHW:0];
   localparam logic [WIDTH-1:0] ONE_W = 1;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SLT = 3'b011;
   localparam logic [2:0] OP_SLL = 3'b100;
   localparam logic [2:0] OP_SRL = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_NOR = 3'b111;

   typedef enum logic [2:0] {
      IDLE, EXEC, SHIFT, MUL, DONE
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               cin_q, cin_d;
   logic               bneg_q, bneg_d;
   logic [2:0]         op_q, op_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [SHW:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;
   logic               zero_q, zero_d;

   logic [WIDTH-1:0] bb;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] diff;
   logic             add_ovf;
   logic             slt_ovf;
   logic             slt;
   logic             fin;

   assign bb      = bneg_q ? ~b_q : b_q;
   assign sum     = {1'b0, a_q} + {1'b0, bb} + {{WIDTH{1'b0}}, cin_q};
   assign add_ovf = (a_q[WIDTH-1] == bb[WIDTH-1]) &&
                    (sum[WIDTH-1] != a_q[WIDTH-1]);
   // SLT always subtracts, independent of bnegate/carry_in
   assign diff    = a_q + ~b_q + ONE_W;
   assign slt_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                    (diff[WIDTH-1] != a_q[WIDTH-1]);
   assign slt     = diff[WIDTH-1] ^ slt_ovf;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cin_d   = cin_q;
      bneg_d  = bneg_q;
      op_d    = op_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      fin     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               cin_d   = bus.carry_in;
               bneg_d  = bus.bnegate;
               op_d    = bus.op;
               cnt_d   = '0;
               acc_d   = '0;
               mcand_d = {{WIDTH{1'b0}}, bus.a};
               unique case (bus.op)
                  OP_SLL, OP_SRL: state_d = SHIFT;
                  OP_MUL:         state_d = MUL;
                  default:        state_d = EXEC;
               endcase
            end
         end
         EXEC: begin
            fin    = 1'b1;
            cout_d = 1'b0;
            ovf_d  = 1'b0;
            unique case (op_q)
               OP_AND: res_d = a_q & bb;
               OP_OR:  res_d = a_q | bb;
               OP_NOR: res_d = ~(a_q | bb);
               OP_ADD: begin
                  res_d  = sum[WIDTH-1:0];
                  cout_d = sum[WIDTH];
                  ovf_d  = add_ovf;
               end
               OP_SLT: res_d = {{(WIDTH-1){1'b0}}, slt};
               default: res_d = '0;
            endcase
         end
         SHIFT: begin
            if (cnt_q == {1'b0, b_q[SHW-1:0]}) begin
               fin    = 1'b1;
               res_d  = a_q;
               cout_d = 1'b0;
               ovf_d  = 1'b0;
            end else begin
               a_d   = (op_q == OP_SRL) ? (a_q >> 1) : (a_q << 1);
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         MUL: begin
            if (cnt_q == CNT_MAX) begin
               fin    = 1'b1;
               res_d  = acc_q[WIDTH-1:0];
               cout_d = |acc_q[2*WIDTH-1:WIDTH];
               ovf_d  = 1'b0;
            end else begin
               if (b_q[0]) acc_d = acc_q + mcand_q;
               mcand_d = mcand_q << 1;
               b_d     = b_q >> 1;
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (fin) begin
         state_d = DONE;
         zero_d  = ~|res_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         bneg_q  <= 1'b0;
         op_q    <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cin_q   <= cin_d;
         bneg_q  <= bneg_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = res_q;
   assign bus.carry_out = cout_q;
   assign bus.overflow  = ovf_q;
   assign bus.zero      = zero_q;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, multi-cycle successor to the 16-bit ripple-carry ALU. Single-cycle ops are AND, OR, NOR, ADD/SUB and SLT. Iterative ops are SLL, SRL (one bit per cycle) and unsigned MUL (shift-add, one bit per cycle).
- Operands enter and results leave through valid/ready handshakes, so the block sits between the register-read stage and writeback of the datapath.
- Only one operation is in flight at a time.

Parameters:
- WIDTH, 16, operand/result width; minimum 4.
- SHW, clog2(WIDTH), derived localparam; shift-amount width, taken from b[SHW-1:0].

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/op presented.
- in_ready  output  1  block can accept; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; also the shift amount for SLL/SRL.
- carry_in  input  1  carry into bit 0 for ADD/SUB.
- bnegate  input  1  invert b for AND/OR/NOR/ADD.
- op  input  3  000 AND, 001 OR, 010 ADD, 011 SLT, 100 SLL, 101 SRL, 110 MUL, 111 NOR.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  registered result.
- carry_out  output  1  ADD: MSB carry; MUL: high product half nonzero; else 0.
- overflow  output  1  ADD: signed overflow; else 0.
- zero  output  1  result == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, carry_out 0, overflow 0, zero 0, internal counter 0.
- rst wins over every other input, including mid-operation. An in-flight op is discarded with no output.
- Accept: on the edge where in_valid && in_ready, latch a, b, carry_in, bnegate and op.
- Ignored inputs: in_valid outside IDLE is ignored. No accept occurs in the same cycle as a result handoff.
- States:
  - IDLE -> EXEC for AND/OR/NOR/ADD/SLT.
  - IDLE -> SHIFT for SLL/SRL.
  - IDLE -> MUL for MUL.
  - EXEC/SHIFT/MUL -> DONE when complete.
  - DONE -> IDLE on out_ready.
- Single-cycle ops:
  - Let bb = bnegate ? ~b : b.
  - ADD: {carry_out, result} = a + bb + carry_in, computed at WIDTH+1 bits.
  - Subtract is bnegate=1 with carry_in=1, driven by the caller.
  - overflow = (a[MSB] == bb[MSB]) && (result[MSB] != a[MSB]).
  - SLT: always computes a - b internally, ignoring bnegate and carry_in. result = {0, sign XOR overflow} (signed less-than).
  - Latency: accept at edge T gives out_valid high after edge T+1.
- SHIFT:
  - shamt = b[SHW-1:0]; upper b bits are ignored.
  - Working register shifts by 1 each cycle, zero-filled.
  - shamt=0 takes 1 cycle with result = a. Otherwise out_valid rises after edge T+1+shamt.
  - carry_out and overflow are 0.
- MUL:
  - Unsigned shift-add over WIDTH iterations using a 2*WIDTH-bit accumulator.
  - out_valid rises after edge T+1+WIDTH.
  - result = product[WIDTH-1:0]; carry_out = |product[2*WIDTH-1:WIDTH]; overflow 0.
- zero is computed from the final registered result for every op.
- DONE:
  - out_valid=1; result and flags held stable until out_ready=1.
  - On that edge: out_valid drops to 0, state returns to IDLE, in_ready becomes 1.
  - Result flags keep their last values; consumers sample them only when out_valid=1.
- Counter: SHW+1 bits, wide enough to hold WIDTH. Wrap is never reached, and it is cleared on each accept.

Test Plan:
- ADD: a=16'h7FFF, b=16'h0001, carry_in=0, bnegate=0 -> out_valid 1 cycle after accept; result 16'h8000, overflow=1, carry_out=0, zero=0.
- SUB and SLT:
  - SUB a=16'h0005, b=16'h0005, bnegate=1, carry_in=1 -> result 0, zero=1, carry_out=1, overflow=0.
  - SLT a=16'hFFFF, b=16'h0001 -> result 16'h0001.
- Shifts:
  - SLL a=16'h0001, b=16'h0004 -> result 16'h0010, out_valid 5 cycles after accept.
  - SRL a=16'h8000, b=16'h000F -> 16'h0001 after 16 cycles.
  - SLL with b=0 -> result a after 1 cycle.
- MUL:
  - 16'h0003 * 16'h0005 -> result 16'h000F, carry_out=0, 17 cycles after accept.
  - 16'h0100 * 16'h0100 -> result 0, carry_out=1, zero=1.
  - Repeat with WIDTH=8.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while in_valid=1 with new operands -> result/flags stable, in_ready=0, new op not taken. Raise out_ready -> in_ready=1 the next cycle, then the new op is accepted.
- Reset mid-MUL: assert rst for 1 cycle at iteration 8 -> next cycle out_valid=0, result=0, in_ready=1, no stale result. Following ADD 2+3 returns 5.
